// File: rtl/two_fifo_pipe_pkg.sv
// Shared widths and field layout for the DP<->VPI buffering block.
// Channel A word: {id, rw, addr, data}; channel B word: {id, data}.
package two_fifo_pipe_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 31;
    localparam int TID_WIDTH  = 16;

    localparam int A_WIDTH = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int B_WIDTH = TID_WIDTH + DATA_WIDTH;

    // Channel A field positions, MSB first
    localparam int A_ID_MSB   = A_WIDTH - 1;
    localparam int A_ID_LSB   = A_WIDTH - TID_WIDTH;
    localparam int A_RW_BIT   = A_ID_LSB - 1;
    localparam int A_ADDR_MSB = A_RW_BIT - 1;
    localparam int A_ADDR_LSB = DATA_WIDTH;
    localparam int A_DATA_MSB = DATA_WIDTH - 1;
    localparam int A_DATA_LSB = 0;

    // Channel B field positions, MSB first
    localparam int B_ID_MSB   = B_WIDTH - 1;
    localparam int B_ID_LSB   = DATA_WIDTH;
    localparam int B_DATA_MSB = DATA_WIDTH - 1;
    localparam int B_DATA_LSB = 0;

    typedef struct packed {
        logic [TID_WIDTH-1:0]  id;
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } a_word_t;

    typedef struct packed {
        logic [TID_WIDTH-1:0]  id;
        logic [DATA_WIDTH-1:0] data;
    } b_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with full/empty derived from a registered count.
// Optional occupancy output when TWO_FIFO_PIPE_LEVEL_EN is defined.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_ctr,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    input  logic             rd_ctr,
    output logic             empty
`ifdef TWO_FIFO_PIPE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop in the same cycle frees the slot a full-FIFO write needs
    assign rd_en = rd_ctr && !empty;
    assign wr_en = wr_ctr && (!full || rd_ctr);

    assign data_out = empty ? '0 : mem[rd_ptr];

`ifdef TWO_FIFO_PIPE_LEVEL_EN
    assign level = count;
`endif

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; array contents are left untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/two_fifo_pipe.sv
// Bidirectional buffer between datapath and VPI side: channel A carries
// requests DP->VPI, channel B carries responses VPI->DP. Channels are
// independent FWFT FIFOs on a shared clock and reset.
// Optional macro TWO_FIFO_PIPE_LEVEL_EN adds A_level/B_level occupancy outputs.
module two_fifo_pipe
    import two_fifo_pipe_pkg::*;
#(
    parameter int A_DEPTH = 4,
    parameter int B_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [A_WIDTH-1:0] A_data_in,
    input  logic               A_wr_ctr,
    output logic               A_full,
    output logic [A_WIDTH-1:0] A_data_out,
    input  logic               A_rd_ctr,
    output logic               A_empty,
    input  logic [B_WIDTH-1:0] B_data_in,
    input  logic               B_wr_ctr,
    output logic               B_full,
    output logic [B_WIDTH-1:0] B_data_out,
    input  logic               B_rd_ctr,
    output logic               B_empty
`ifdef TWO_FIFO_PIPE_LEVEL_EN
    ,
    output logic [$clog2(A_DEPTH):0] A_level,
    output logic [$clog2(B_DEPTH):0] B_level
`endif
);

    sync_fifo #(.WIDTH(A_WIDTH), .DEPTH(A_DEPTH)) u_fifo_a (
        .clk      (clk),
        .reset    (reset),
        .data_in  (A_data_in),
        .wr_ctr   (A_wr_ctr),
        .full     (A_full),
        .data_out (A_data_out),
        .rd_ctr   (A_rd_ctr),
        .empty    (A_empty)
`ifdef TWO_FIFO_PIPE_LEVEL_EN
        ,
        .level    (A_level)
`endif
    );

    sync_fifo #(.WIDTH(B_WIDTH), .DEPTH(B_DEPTH)) u_fifo_b (
        .clk      (clk),
        .reset    (reset),
        .data_in  (B_data_in),
        .wr_ctr   (B_wr_ctr),
        .full     (B_full),
        .data_out (B_data_out),
        .rd_ctr   (B_rd_ctr),
        .empty    (B_empty)
`ifdef TWO_FIFO_PIPE_LEVEL_EN
        ,
        .level    (B_level)
`endif
    );

endmodule

// File: tb/tb_two_fifo_pipe.sv
// Testbench for two_fifo_pipe: directed steps followed by random traffic,
// checked against queue-based models of both channels.
module tb_two_fifo_pipe;
    import two_fifo_pipe_pkg::*;

    localparam int AD = 4;
    localparam int BD = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [A_WIDTH-1:0] A_data_in;
    logic               A_wr_ctr;
    logic               A_full;
    logic [A_WIDTH-1:0] A_data_out;
    logic               A_rd_ctr;
    logic               A_empty;
    logic [B_WIDTH-1:0] B_data_in;
    logic               B_wr_ctr;
    logic               B_full;
    logic [B_WIDTH-1:0] B_data_out;
    logic               B_rd_ctr;
    logic               B_empty;
`ifdef TWO_FIFO_PIPE_LEVEL_EN
    logic [$clog2(AD):0] A_level;
    logic [$clog2(BD):0] B_level;
`endif

    int checks = 0;
    int errors = 0;

    logic [A_WIDTH-1:0] qa[$];
    logic [B_WIDTH-1:0] qb[$];

    two_fifo_pipe #(.A_DEPTH(AD), .B_DEPTH(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .A_data_in  (A_data_in),
        .A_wr_ctr   (A_wr_ctr),
        .A_full     (A_full),
        .A_data_out (A_data_out),
        .A_rd_ctr   (A_rd_ctr),
        .A_empty    (A_empty),
        .B_data_in  (B_data_in),
        .B_wr_ctr   (B_wr_ctr),
        .B_full     (B_full),
        .B_data_out (B_data_out),
        .B_rd_ctr   (B_rd_ctr),
        .B_empty    (B_empty)
`ifdef TWO_FIFO_PIPE_LEVEL_EN
        ,
        .A_level    (A_level),
        .B_level    (B_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [A_WIDTH-1:0] obs, input logic [A_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue models
    task automatic check_all(input string tag);
        logic [A_WIDTH-1:0] ea;
        logic [B_WIDTH-1:0] eb;
        ea = (qa.size() != 0) ? qa[0] : '0;
        eb = (qb.size() != 0) ? qb[0] : '0;
        chk({tag, ":A_empty"}, A_WIDTH'(A_empty), A_WIDTH'(qa.size() == 0));
        chk({tag, ":A_full"},  A_WIDTH'(A_full),  A_WIDTH'(qa.size() == AD));
        chk({tag, ":A_data"},  A_data_out, ea);
        chk({tag, ":B_empty"}, A_WIDTH'(B_empty), A_WIDTH'(qb.size() == 0));
        chk({tag, ":B_full"},  A_WIDTH'(B_full),  A_WIDTH'(qb.size() == BD));
        chk({tag, ":B_data"},  A_WIDTH'(B_data_out), A_WIDTH'(eb));
`ifdef TWO_FIFO_PIPE_LEVEL_EN
        chk({tag, ":A_level"}, A_WIDTH'(A_level), A_WIDTH'(qa.size()));
        chk({tag, ":B_level"}, A_WIDTH'(B_level), A_WIDTH'(qb.size()));
`endif
    endtask

    // One rising edge: model reacts to the inputs present at the edge
    task automatic tick();
        bit ra, wa, rb, wb;
        @(posedge clk);
        ra = A_rd_ctr && (qa.size() > 0);
        wa = A_wr_ctr && ((qa.size() < AD) || A_rd_ctr);
        rb = B_rd_ctr && (qb.size() > 0);
        wb = B_wr_ctr && ((qb.size() < BD) || B_rd_ctr);
        if (ra) void'(qa.pop_front());
        if (wa) qa.push_back(A_data_in);
        if (rb) void'(qb.pop_front());
        if (wb) qb.push_back(B_data_in);
        #1;
    endtask

    task automatic idle_inputs();
        A_wr_ctr = 0; A_rd_ctr = 0; A_data_in = '0;
        B_wr_ctr = 0; B_rd_ctr = 0; B_data_in = '0;
    endtask

    task automatic fill_a4();
        for (int i = 1; i <= 4; i++) begin
            A_wr_ctr = 1; A_data_in = A_WIDTH'(i);
            tick();
            check_all("fill");
        end
        A_wr_ctr = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_A_data", A_data_out, '0);
        @(negedge clk);
        reset = 0;
        tick();
        check_all("idle");
        chk("idle_A_empty", A_WIDTH'(A_empty), 1);
        chk("idle_B_empty", A_WIDTH'(B_empty), 1);

        // Fill A, overflow write dropped, drain in order
        fill_a4();
        chk("A_full_after4", A_WIDTH'(A_full), 1);
        A_wr_ctr = 1; A_data_in = A_WIDTH'(5);
        tick();
        check_all("overflow");
        A_wr_ctr = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("A_pop_order", A_data_out, A_WIDTH'(i));
            chk("B_stays_empty", A_WIDTH'(B_empty), 1);
            A_rd_ctr = 1;
            tick();
            check_all("drain");
        end
        A_rd_ctr = 0;
        chk("A_empty_after_drain", A_WIDTH'(A_empty), 1);

        // B: write while empty, then simultaneous read and write
        B_wr_ctr = 1; B_data_in = B_WIDTH'(8'hAB);
        tick();
        chk("B_fwft_AB", A_WIDTH'(B_data_out), A_WIDTH'(8'hAB));
        chk("B_nonempty", A_WIDTH'(B_empty), 0);
        B_rd_ctr = 1; B_data_in = B_WIDTH'(8'hCD);
        tick();
        chk("B_rw_CD", A_WIDTH'(B_data_out), A_WIDTH'(8'hCD));
        chk("B_rw_nonempty", A_WIDTH'(B_empty), 0);
        check_all("B_rw");
        B_wr_ctr = 0;
        tick();
        B_rd_ctr = 0;
        check_all("B_drained");

        // A full: simultaneous read/write keeps it full
        fill_a4();
        A_wr_ctr = 1; A_rd_ctr = 1; A_data_in = A_WIDTH'(9);
        tick();
        chk("A_full_rw", A_WIDTH'(A_full), 1);
        A_wr_ctr = 0;
        for (int i = 0; i < 4; i++) begin
            chk("A_pop_after_rw", A_data_out, A_WIDTH'((i < 3) ? i + 2 : 9));
            tick();
            check_all("drain_rw");
        end
        A_rd_ctr = 0;

        // Read on empty B is ignored
        B_rd_ctr = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("B_empty_rd", A_WIDTH'(B_empty), 1);
            chk("B_empty_data", A_WIDTH'(B_data_out), '0);
        end
        B_rd_ctr = 0;

        // Asynchronous reset with A holding two entries
        for (int i = 1; i <= 2; i++) begin
            A_wr_ctr = 1; A_data_in = A_WIDTH'(i + 16);
            tick();
        end
        A_wr_ctr = 0;
        chk("A_two_entries", A_WIDTH'(A_empty), 0);
        #2;
        reset = 1;
        qa.delete();
        qb.delete();
        #1;
        check_all("async_reset");
        chk("async_A_empty", A_WIDTH'(A_empty), 1);
        #1;
        reset = 0;
        A_wr_ctr = 1; A_data_in = A_WIDTH'(7);
        tick();
        A_wr_ctr = 0;
        chk("A_after_reset_7", A_data_out, A_WIDTH'(7));
        check_all("post_reset");

        // Random traffic on both channels
        for (int n = 0; n < 400; n++) begin
            A_wr_ctr  = ($urandom_range(0, 99) < 55);
            A_rd_ctr  = ($urandom_range(0, 99) < 45);
            A_data_in = A_WIDTH'({$urandom, $urandom, $urandom});
            B_wr_ctr  = ($urandom_range(0, 99) < 45);
            B_rd_ctr  = ($urandom_range(0, 99) < 55);
            B_data_in = B_WIDTH'({$urandom, $urandom});
            tick();
            check_all("random");
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/two_fifo_pipe.md
Name: two_fifo_pipe

Overview:
Bidirectional buffering block between the datapath (DP) side and the simulator VPI side. It contains two independent synchronous FIFOs on one clock:
- Channel A carries requests DP→VPI: {id, rw flag, address, data}.
- Channel B carries responses VPI→DP: {id, data}.
Both channels use first-word-fall-through (FWFT) output and full/empty flow control.

Parameters:
- DATA_WIDTH, 32, payload data width
- ADDR_WIDTH, 31, request address width
- TID_WIDTH, 16, transaction id width
- A_WIDTH, TID_WIDTH+1+ADDR_WIDTH+DATA_WIDTH (80), channel A word width
- B_WIDTH, TID_WIDTH+DATA_WIDTH (48), channel B word width
- A_DEPTH, 4, channel A entries; power of two, ≥2
- B_DEPTH, 4, channel B entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- A_data_in  in  A_WIDTH  request word written into A
- A_wr_ctr  in  1  A write enable
- A_full  out  1  A holds A_DEPTH entries
- A_data_out  out  A_WIDTH  head of A (FWFT)
- A_rd_ctr  in  1  A read/pop enable
- A_empty  out  1  A holds 0 entries
- B_data_in  in  B_WIDTH  response word written into B
- B_wr_ctr  in  1  B write enable
- B_full  out  1  B full
- B_data_out  out  B_WIDTH  head of B (FWFT)
- B_rd_ctr  in  1  B read/pop enable
- B_empty  out  1  B empty

Behaviour:
- Reset applies to both channels. Asserting reset asynchronously clears read/write pointers and counts, including mid-operation; all stored words are discarded.
  - During reset: *_empty=1, *_full=0, *_data_out=0.
  - Storage arrays are not reset.
- The two channels are fully independent; no cross-channel interaction.
- Per channel, with count = occupancy 0..DEPTH:
  - Write accepted when wr_ctr && (!full || rd_ctr). The word is stored at wr_ptr and wr_ptr increments, wrapping at DEPTH.
  - Read accepted when rd_ctr && !empty. rd_ptr increments, wrapping at DEPTH.
  - Write while full without a read: dropped, no state change. Read while empty: ignored.
  - Simultaneous accepted read and write: count unchanged, pointers both advance.
  - Simultaneous write and read while empty: only the write takes effect; count becomes 1.
  - empty = (count==0) and full = (count==DEPTH), both registered-state derived, no combinational path from inputs.
  - data_out = mem[rd_ptr] when !empty, else 0. Data written at edge N is visible on data_out after edge N when the FIFO was empty, i.e. write-to-read latency is 1 cycle. After a pop, the next word appears immediately following the same edge.
  - Ordering is strictly FIFO. Pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro TWO_FIFO_PIPE_LEVEL_EN.
- When defined: adds outputs A_level [log2(A_DEPTH):0] and B_level [log2(B_DEPTH):0], equal to the current occupancy count (0 after reset).
- When undefined: these ports do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package two_fifo_pipe_pkg holds:
  - width constants DATA_WIDTH, ADDR_WIDTH, TID_WIDTH, A_WIDTH, B_WIDTH
  - field offset constants for the A word: id [A_WIDTH-1 -: TID_WIDTH], rw flag next bit, then address, then data in the LSBs
  - field offset constants for the B word: id MSBs, data LSBs
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated twice: A with A_WIDTH/A_DEPTH, B with B_WIDTH/B_DEPTH.

Test Plan:
- Reset then idle → A_empty=1, B_empty=1, A_full=0, B_full=0, both data_out=0.
- Write A words 0x1, 0x2, 0x3, 0x4 on consecutive cycles → A_full=1 after 4th edge. 5th write of 0x5 is dropped. Pop 4 times → reads 1, 2, 3, 4 then A_empty=1. B stays empty throughout.
- B: write 0xAB while empty → B_data_out=0xAB, B_empty=0 one edge later. Assert B_rd_ctr and B_wr_ctr(0xCD) together → B_data_out=0xCD, count stays 1.
- A full with 4 entries; simultaneous read+write of 0x9 → A_full stays 1. Subsequent pops yield 2, 3, 4, 9.
- Read on empty B with B_rd_ctr=1 for 3 cycles → no change, B_empty=1, B_data_out=0.
- Fill A with 2 entries, assert reset asynchronously between edges → A_empty=1 immediately, no clock required. After release, new write 0x7 reads back as 0x7.
